keypad_scanner: RTL and testbench

- Upstream stage of the keypad-to-dot-matrix path.
- Drives the 4x4 keypad rows, samples the columns and debounces over whole scan frames.
- Emits a single-cycle key-press event with a 4-bit key code, which the dot-matrix display stage latches for display.
- Replaces the raw per-slot row decode, which has no debounce and no press/release events.

---
 rtl/keypad_pkg.sv | 50 +++++
 rtl/keypad_row_decode.sv | 17 +
 rtl/keypad_scanner.sv | 219 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types: row drive constants, scanner FSM states and the 4x4 key decode map.
package keypad_pkg;

    localparam logic [3:0] ROW0 = 4'b1110;
    localparam logic [3:0] ROW1 = 4'b1101;
    localparam logic [3:0] ROW2 = 4'b1011;
    localparam logic [3:0] ROW3 = 4'b0111;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } state_t;

    typedef struct packed {
        logic      hit;
        key_code_t code;
    } key_hit_t;

    // Row and column are both one-cold; anything else on the columns is not a hit.
    function automatic key_hit_t decode_key(input logic [3:0] row, input logic [3:0] col);
        key_hit_t r_res;
        r_res.hit  = 1'b1;
        r_res.code = 4'h0;
        case ({row, col})
            {ROW0, 4'b1110}: r_res.code = 4'h7;
            {ROW0, 4'b1101}: r_res.code = 4'h4;
            {ROW0, 4'b1011}: r_res.code = 4'h1;
            {ROW0, 4'b0111}: r_res.code = 4'h0;
            {ROW1, 4'b1110}: r_res.code = 4'h8;
            {ROW1, 4'b1101}: r_res.code = 4'h5;
            {ROW1, 4'b1011}: r_res.code = 4'h2;
            {ROW1, 4'b0111}: r_res.code = 4'hA;
            {ROW2, 4'b1110}: r_res.code = 4'h9;
            {ROW2, 4'b1101}: r_res.code = 4'h6;
            {ROW2, 4'b1011}: r_res.code = 4'h3;
            {ROW2, 4'b0111}: r_res.code = 4'hB;
            {ROW3, 4'b1110}: r_res.code = 4'hC;
            {ROW3, 4'b1101}: r_res.code = 4'hD;
            {ROW3, 4'b1011}: r_res.code = 4'hE;
            {ROW3, 4'b0111}: r_res.code = 4'hF;
            default:         r_res.hit  = 1'b0;
        endcase
        return r_res;
    endfunction

endpackage

// File: rtl/keypad_row_decode.sv
// Combinational decode of one scan slot: driven row plus sensed columns to hit/key code.
module keypad_row_decode
    import keypad_pkg::*;
(
    input  logic [3:0] i_row,
    input  logic [3:0] i_col,
    output logic       o_hit,
    output key_code_t  o_code
);

    key_hit_t w_dec;

    assign w_dec  = decode_key(i_row, i_col);
    assign o_hit  = w_dec.hit;
    assign o_code = w_dec.code;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with whole-frame debounce and single-cycle press events.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 250000,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned REPEAT_FRAMES   = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypadCol,
    output logic [3:0] keypadRow,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_FRAMES);

    if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_cfg_check
        $error("keypad_scanner: illegal parameter combination");
    end

    logic [3:0]      r_col_meta;
    logic [3:0]      r_col_sync;
    logic [DivW-1:0] r_div;
    logic [3:0]      r_row;
    logic            r_lat_hit;
    key_code_t       r_lat_code;
    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    key_code_t       r_cand;
    key_code_t       r_key_code;
    logic            r_key_valid;
    logic            r_key_held;

    logic            w_tick;
    logic            w_frame_end;
    logic            w_slot_hit;
    key_code_t       w_slot_code;
    logic            w_frame_hit;
    key_code_t       w_frame_code;
    state_t          w_state_d;
    logic [CntW-1:0] w_cnt_d;
    key_code_t       w_cand_d;
    logic            w_accept;
    logic            w_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_meta <= 4'b1111;
            r_col_sync <= 4'b1111;
        end else begin
            r_col_meta <= keypadCol;
            r_col_sync <= r_col_meta;
        end
    end

    assign w_tick      = (r_div == DivMax);
    assign w_frame_end = w_tick && (r_row == ROW3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_row <= ROW0;
        end else if (w_tick) begin
            r_div <= '0;
            r_row <= {r_row[2:0], r_row[3]};
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    keypad_row_decode u_row_decode (
        .i_row  (r_row),
        .i_col  (r_col_sync),
        .o_hit  (w_slot_hit),
        .o_code (w_slot_code)
    );

    // The earliest hit in the frame wins; the final slot is folded in combinationally.
    assign w_frame_hit  = r_lat_hit | w_slot_hit;
    assign w_frame_code = r_lat_hit ? r_lat_code : w_slot_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_hit  <= 1'b0;
            r_lat_code <= 4'h0;
        end else if (w_frame_end) begin
            r_lat_hit  <= 1'b0;
            r_lat_code <= 4'h0;
        end else if (w_tick && !r_lat_hit && w_slot_hit) begin
            r_lat_hit  <= 1'b1;
            r_lat_code <= w_slot_code;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_cand_d  = r_cand;
        w_accept  = 1'b0;
        if (w_frame_end) begin
            unique case (r_state)
                IDLE: begin
                    if (w_frame_hit) begin
                        w_cand_d  = w_frame_code;
                        w_cnt_d   = CntW'(1);
                        w_state_d = PRESS;
                    end
                end
                PRESS: begin
                    if (!w_frame_hit) begin
                        w_cnt_d   = '0;
                        w_state_d = IDLE;
                    end else if (w_frame_code == r_cand) begin
                        w_cnt_d = r_cnt + 1'b1;
                    end else begin
                        w_cand_d = w_frame_code;
                        w_cnt_d  = CntW'(1);
                    end
                end
                HELD: begin
                    if (!w_frame_hit) begin
                        w_cnt_d   = CntW'(1);
                        w_state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_frame_hit) begin
                        w_cnt_d   = '0;
                        w_state_d = HELD;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            endcase
            // Threshold checks follow the case so DEBOUNCE_FRAMES==1 resolves in one frame.
            if (w_state_d == PRESS && w_cnt_d == CntMax) begin
                w_accept  = 1'b1;
                w_cnt_d   = '0;
                w_state_d = HELD;
            end
            if (w_state_d == RELEASE && w_cnt_d == CntMax) begin
                w_cnt_d   = '0;
                w_state_d = IDLE;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RepW-1:0] RepMax = RepW'(REPEAT_FRAMES);

    logic [RepW-1:0] r_rep;
    logic [RepW-1:0] w_rep_d;
    logic            w_repeat;

    always_comb begin
        w_rep_d  = r_rep;
        w_repeat = 1'b0;
        if (w_frame_end) begin
            if (r_state == HELD && w_state_d == HELD && w_frame_hit &&
                w_frame_code == r_key_code) begin
                if (r_rep + 1'b1 == RepMax) begin
                    w_repeat = 1'b1;
                    w_rep_d  = '0;
                end else begin
                    w_rep_d = r_rep + 1'b1;
                end
            end else begin
                w_rep_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep <= '0;
        end else begin
            r_rep <= w_rep_d;
        end
    end

    assign w_pulse = w_accept | w_repeat;
`else
    assign w_pulse = w_accept;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cand      <= 4'h0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_cand      <= w_cand_d;
            r_key_valid <= w_pulse;
            r_key_held  <= (w_state_d == HELD) || (w_state_d == RELEASE);
            if (w_accept) begin
                r_key_code <= w_cand_d;
            end
        end
    end

    assign keypadRow = r_row;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives the columns, expected press
// events (code and cycle) are queued with the stimulus and popped on every key_valid.
module tb_keypad_scanner;

    localparam int unsigned SD = 4;
    localparam int unsigned DF = 3;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RF = 2;
`else
    localparam int unsigned RF = 40;
`endif
    localparam int FrameCyc = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] code;
    logic       valid;
    logic       held;

    logic [15:0] keys = '0;
    logic        ovr_en = 1'b0;
    logic [3:0]  ovr_row = 4'b1111;
    logic [3:0]  ovr_col = 4'b1111;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DF),
        .REPEAT_FRAMES   (RF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keypadCol (col),
        .keypadRow (row),
        .key_code  (code),
        .key_valid (valid),
        .key_held  (held)
    );

    function automatic logic [3:0] key_at(input int r, input int c);
        case (r * 4 + c)
            0:  return 4'h7;
            1:  return 4'h4;
            2:  return 4'h1;
            3:  return 4'h0;
            4:  return 4'h8;
            5:  return 4'h5;
            6:  return 4'h2;
            7:  return 4'hA;
            8:  return 4'h9;
            9:  return 4'h6;
            10: return 4'h3;
            11: return 4'hB;
            12: return 4'hC;
            13: return 4'hD;
            14: return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] col_for(input logic [3:0] rw, input logic [15:0] k);
        logic [3:0] cv;
        int         r;
        cv = 4'b1111;
        r  = -1;
        for (int i = 0; i < 4; i++) begin
            if (!rw[i]) r = i;
        end
        if (r >= 0) begin
            for (int ci = 0; ci < 4; ci++) begin
                if (k[key_at(r, ci)]) cv[ci] = 1'b0;
            end
        end
        return cv;
    endfunction

    always_comb begin
        col = col_for(row, keys);
        if (ovr_en && row == ovr_row) col = ovr_col;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {28'd0, code}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_code", {28'd0, code}, {28'd0, e.code});
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_frames(input int n);
        repeat (FrameCyc * n) @(negedge clk);
    endtask

    // Expect a pulse visible just after the end of frame f.
    task automatic expect_at(input logic [3:0] k, input int f);
        exp_t e;
        e.code = k;
        e.cyc  = FrameCyc * f;
        exp_q.push_back(e);
    endtask

    function automatic int cur_frame();
        return cyc / FrameCyc;
    endfunction

    function automatic logic [15:0] key_bit(input int k);
        logic [15:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        int         b;
        logic [3:0] er;

        repeat (5) @(negedge clk);
        check("rst_row", {28'd0, row}, 32'b1110);
        check("rst_code", {28'd0, code}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_held", {31'd0, held}, 32'd0);
        rst = 1'b0;

        er = 4'b1110;
        for (int s = 0; s < 4; s++) begin
            repeat (2) @(negedge clk);
            check("row_rotate", {28'd0, row}, {28'd0, er});
            er = {er[2:0], er[3]};
            repeat (2) @(negedge clk);
        end
        check("row_wrap", {28'd0, row}, 32'b1110);

        // Key 5 held 6 frames, then released.
        b    = cur_frame();
        keys = key_bit(5);
        expect_at(4'h5, b + 3);
`ifdef KEYPAD_AUTOREPEAT_EN
        expect_at(4'h5, b + 5);
`endif
        wait_frames(2);
        check("held_before_accept", {31'd0, held}, 32'd0);
        wait_frames(1);
        check("held_after_accept", {31'd0, held}, 32'd1);
        wait_frames(3);
        keys = '0;
        wait_frames(2);
        check("held_during_release", {31'd0, held}, 32'd1);
        wait_frames(1);
        check("held_after_release", {31'd0, held}, 32'd0);
        check("code_holds", {28'd0, code}, 32'h5);
        wait_frames(1);
        check("q_empty_key5", exp_q.size(), 32'd0);

        // Bounce on key 9: present, absent, then present for three frames.
        b    = cur_frame();
        keys = key_bit(9);
        wait_frames(1);
        keys = '0;
        wait_frames(1);
        keys = key_bit(9);
        expect_at(4'h9, b + 5);
        wait_frames(3);
        check("held_bounce", {31'd0, held}, 32'd1);
        keys = '0;
        wait_frames(4);
        check("q_empty_bounce", exp_q.size(), 32'd0);

        // Keys 1 and F together: the earlier row wins.
        b    = cur_frame();
        keys = key_bit(1) | key_bit(15);
        expect_at(4'h1, b + 3);
        wait_frames(4);
        keys = '0;
        wait_frames(4);
        check("code_two_keys", {28'd0, code}, 32'h1);
        check("q_empty_two_keys", exp_q.size(), 32'd0);

        // Two columns low on one row is not a hit.
        ovr_en  = 1'b1;
        ovr_row = 4'b1101;
        ovr_col = 4'b0011;
        wait_frames(5);
        check("held_multi_col", {31'd0, held}, 32'd0);
        check("code_multi_col", {28'd0, code}, 32'h1);
        check("q_empty_multi_col", exp_q.size(), 32'd0);
        ovr_en = 1'b0;

        // Candidate switches from 7 to C mid-debounce.
        b    = cur_frame();
        keys = key_bit(7);
        wait_frames(2);
        keys = key_bit(12);
        expect_at(4'hC, b + 5);
        wait_frames(3);
        check("held_switch", {31'd0, held}, 32'd1);
        keys = '0;
        wait_frames(4);
        check("q_empty_switch", exp_q.size(), 32'd0);

        // Every key once.
        for (int k = 0; k < 16; k++) begin
            b    = cur_frame();
            keys = key_bit(k);
            expect_at(4'(k), b + 3);
            wait_frames(3);
            keys = '0;
            wait_frames(4);
        end
        check("q_empty_sweep", exp_q.size(), 32'd0);
        check("code_sweep_last", {28'd0, code}, 32'hF);

`ifdef KEYPAD_AUTOREPEAT_EN
        b    = cur_frame();
        keys = key_bit(14);
        expect_at(4'hE, b + 3);
        expect_at(4'hE, b + 5);
        expect_at(4'hE, b + 7);
        expect_at(4'hE, b + 9);
        wait_frames(9);
        keys = '0;
        wait_frames(4);
        check("q_empty_repeat", exp_q.size(), 32'd0);
`endif

        // Reset mid-debounce: key 2 for two frames, then reset mid-frame.
        keys = key_bit(2);
        wait_frames(2);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_row", {28'd0, row}, 32'b1110);
        check("midrst_code", {28'd0, code}, 32'h0);
        check("midrst_held", {31'd0, held}, 32'd0);
        keys = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_frames(4);
        check("q_empty_midrst", exp_q.size(), 32'd0);
        check("held_midrst_after", {31'd0, held}, 32'd0);

        // Reset while a key is held.
        b    = cur_frame();
        keys = key_bit(3);
        expect_at(4'h3, b + 3);
        wait_frames(4);
        check("held_before_rst", {31'd0, held}, 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("heldrst_row", {28'd0, row}, 32'b1110);
        check("heldrst_code", {28'd0, code}, 32'h0);
        check("heldrst_valid", {31'd0, valid}, 32'd0);
        check("heldrst_held", {31'd0, held}, 32'd0);
        keys = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_frames(4);
        check("q_empty_end", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
